// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage holding the PC, driving a synchronous ROM, squashing on redirect and honouring stall
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [4:0]         if_opcode,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic [CNT_W-1:0]   bubble_cnt
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              req_valid;
    logic              bubble;

    assign imem_addr = stall ? req_pc : pc;
    assign if_opcode = if_instr[INSTR_W-1 -: 5];
    assign bubble    = redirect || (!stall && !req_valid);

    // PC, outstanding ROM request and IF/ID register; redirect beats stall beats normal flow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            req_valid <= 1'b0;
            if_instr  <= '0;
            if_pc     <= '0;
            if_valid  <= 1'b0;
        end else if (redirect) begin
            pc        <= redirect_pc;
            req_pc    <= pc;
            req_valid <= 1'b0;
            if_instr  <= '0;
            if_pc     <= req_pc;
            if_valid  <= 1'b0;
        end else if (!stall) begin
            pc        <= pc + ADDR_W'(1);
            req_pc    <= pc;
            req_valid <= 1'b1;
            if_instr  <= req_valid ? imem_rdata : '0;
            if_pc     <= req_pc;
            if_valid  <= req_valid;
        end
    end

    // saturating count of bubbles loaded into the IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
endmodule
